fan_pwm_ramp_ctrl: RTL and testbench
====================================

FAN_PWM_RAMP_CTRL -- requirements
Module: fan_pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter StepCycles, default 133, clock cycles per duty level; PWM period = 15*StepCycles (1995 cycles, ~25 kHz at 50 MHz soc_clk).
REQ-002 SHALL have parameter RampPeriods, default 16, PWM periods between successive one-level duty steps.
REQ-003 SHALL have parameter KickPeriods, default 12500, PWM periods of full-speed kick-start (~0.5 s).
REQ-004 SHALL have port clk_i  input  1  single clock (soc_clk).
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pwm_setting_i  input  4  requested fan level 0..15 (switches, asynchronous to clk_i).
REQ-007 SHALL have port fan_pwm_o  output  1  registered PWM drive to fan.
REQ-008 SHALL have port duty_o  output  4  duty level currently applied.
REQ-009 SHALL have port busy_o  output  1  high while in KICK or RAMP.

Function
REQ-010 SHALL synchronise pwm_setting_i through two flops; the synchronised value is the target.
REQ-011 SHALL run a period counter 0..15*StepCycles-1, wrapping to 0; the cycle with counter at max is the period boundary.
REQ-012 SHALL sample target, update duty and evaluate FSM transitions only at the period boundary; duty is constant within a period (glitch-free).
REQ-013 SHALL drive fan_pwm_o, one cycle after the counter value, high iff counter < duty*StepCycles; duty 0 gives constant low, duty 15 constant high.
REQ-014 SHALL compute duty*StepCycles at a width sufficient for 15*StepCycles without truncation.
REQ-015 SHALL implement FSM states IDLE, KICK, RAMP, HOLD.
REQ-016 IDLE: duty 0; target!=0 at boundary -> KICK, duty 15, kick counter cleared.
REQ-017 KICK: duty 15; target==0 at boundary -> IDLE, duty 0; after KickPeriods full periods -> HOLD if target==15, else RAMP with ramp counter cleared.
REQ-018 RAMP: every RampPeriods-th boundary, duty steps by exactly one toward target; when duty equals target -> HOLD.
REQ-019 RAMP target change mid-ramp SHALL redirect the ramp direction without clearing the ramp counter and without a new kick.
REQ-020 HOLD: target!=duty and target!=0 -> RAMP, ramp counter cleared; target==duty stays HOLD.
REQ-021 In KICK, RAMP or HOLD, target==0 at a boundary SHALL force IDLE with duty 0 from the next period (immediate stop, no ramp down).
REQ-022 busy_o SHALL be registered high exactly while state is KICK or RAMP.
REQ-023 Target changes within a period SHALL have no effect; only the value at the boundary counts.
REQ-024 Kick and ramp counters SHALL saturate-free wrap only via explicit clear; KickPeriods/RampPeriods of 1 SHALL be legal.

Reset
REQ-025 rst_ni low SHALL asynchronously force state IDLE, period/kick/ramp counters 0, sync flops 0, duty_o 0, fan_pwm_o 0, busy_o 0.
REQ-026 Reset deassertion SHALL start at counter 0 with a full period before the first boundary; reset mid-KICK/RAMP restarts from IDLE.

Verification (StepCycles=2 -> period 30, RampPeriods=2, KickPeriods=3)
REQ-027 Setting 0->8 from IDLE -> duty_o 15 for 3 periods (30/30 high), then 14,13,..,8 each 2 periods, busy_o falls entering HOLD; HOLD period shows 16/30 high cycles.
REQ-028 In HOLD at 8, setting->12 -> no kick, duty 9,10,11,12 each 2 periods, busy_o high during ramp only.
REQ-029 During RAMP (duty 11 heading to 5), setting->0 -> next boundary duty_o 0, fan_pwm_o constant low, busy_o 0, state IDLE.
REQ-030 Setting 0->15 -> 3 kick periods then HOLD directly, fan_pwm_o never low, busy_o low after kick.
REQ-031 rst_ni pulsed low mid-KICK -> fan_pwm_o, duty_o, busy_o 0 in same cycle (asynchronous); after release with setting 4 -> new kick after first boundary.
REQ-032 Setting toggled 0->9->0 entirely inside one period -> no state change, duty_o stays 0.

Source files
------------

// File: rtl/fan_pwm_ramp_ctrl.sv
// Fan PWM controller: a full-speed kick-start, then a ramp of one duty level at a time
// toward the synchronised switch setting. Duty changes only at PWM period boundaries.
module fan_pwm_ramp_ctrl #(
  parameter int unsigned StepCycles  = 133,
  parameter int unsigned RampPeriods = 16,
  parameter int unsigned KickPeriods = 12500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] pwm_setting_i,
  output logic       fan_pwm_o,
  output logic [3:0] duty_o,
  output logic       busy_o
);

  localparam int unsigned Period = 15 * StepCycles;
  localparam int unsigned CntW   = $clog2(Period);
  localparam int unsigned ThrW   = $clog2(Period + 1);
  localparam int unsigned KickW  = $clog2(KickPeriods + 1);
  localparam int unsigned RampW  = $clog2(RampPeriods + 1);

  localparam logic [CntW-1:0]  CntMax   = CntW'(Period - 1);
  localparam logic [KickW-1:0] KickLast = KickW'(KickPeriods - 1);
  localparam logic [RampW-1:0] RampLast = RampW'(RampPeriods - 1);

  typedef enum logic [1:0] {StIdle, StKick, StRamp, StHold} state_e;

  state_e           r_state;
  logic [3:0]       r_sync1;
  logic [3:0]       r_target;
  logic [CntW-1:0]  r_cnt;
  logic [KickW-1:0] r_kick;
  logic [RampW-1:0] r_ramp;
  logic [3:0]       r_duty;
  logic             r_pwm;
  logic             r_busy;

  logic             w_bound;
  logic [ThrW-1:0]  w_thresh;
  logic [3:0]       w_step;

  assign w_bound  = (r_cnt == CntMax);
  assign w_thresh = ThrW'(r_duty) * ThrW'(StepCycles);
  // One level toward the target; only used when duty differs from target.
  assign w_step   = (r_target > r_duty) ? r_duty + 4'd1 : r_duty - 4'd1;

  assign fan_pwm_o = r_pwm;
  assign duty_o    = r_duty;
  assign busy_o    = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1  <= '0;
      r_target <= '0;
      r_cnt    <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_sync1  <= pwm_setting_i;
      r_target <= r_sync1;
      r_cnt    <= w_bound ? '0 : r_cnt + CntW'(1);
      r_pwm    <= (ThrW'(r_cnt) < w_thresh);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_duty  <= '0;
      r_kick  <= '0;
      r_ramp  <= '0;
      r_busy  <= 1'b0;
    end else if (w_bound) begin
      unique case (r_state)
        StIdle: begin
          if (r_target != 4'd0) begin
            r_state <= StKick;
            r_duty  <= 4'd15;
            r_kick  <= '0;
            r_busy  <= 1'b1;
          end
        end
        StKick: begin
          if (r_target == 4'd0) begin
            r_state <= StIdle;
            r_duty  <= '0;
            r_busy  <= 1'b0;
          end else if (r_kick == KickLast) begin
            if (r_target == 4'd15) begin
              r_state <= StHold;
              r_busy  <= 1'b0;
            end else begin
              // Leaving the kick counts as the first ramp step.
              r_state <= StRamp;
              r_duty  <= w_step;
              r_ramp  <= '0;
            end
          end else begin
            r_kick <= r_kick + KickW'(1);
          end
        end
        StRamp: begin
          if (r_target == 4'd0) begin
            r_state <= StIdle;
            r_duty  <= '0;
            r_busy  <= 1'b0;
          end else if (r_duty == r_target) begin
            r_state <= StHold;
            r_busy  <= 1'b0;
          end else if (r_ramp == RampLast) begin
            r_duty <= w_step;
            r_ramp <= '0;
            if (w_step == r_target) begin
              r_state <= StHold;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ramp <= r_ramp + RampW'(1);
          end
        end
        StHold: begin
          if (r_target == 4'd0) begin
            r_state <= StIdle;
            r_duty  <= '0;
            r_busy  <= 1'b0;
          end else if (r_target != r_duty) begin
            r_state <= StRamp;
            r_duty  <= w_step;
            r_ramp  <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_duty  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fan_pwm_ramp_ctrl.sv
// Directed bench for fan_pwm_ramp_ctrl with StepCycles=2 (period 30), RampPeriods=2,
// KickPeriods=3. Each period is checked for duty, busy and the count of high PWM cycles.
module tb_fan_pwm_ramp_ctrl;

  localparam int Period = 30;

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] pwm_setting_i;
  logic       fan_pwm_o;
  logic [3:0] duty_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  fan_pwm_ramp_ctrl #(
    .StepCycles (2),
    .RampPeriods(2),
    .KickPeriods(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pwm_setting_i(pwm_setting_i),
    .fan_pwm_o    (fan_pwm_o),
    .duty_o       (duty_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called just after a boundary edge; consumes exactly one PWM period.
  task automatic run_period(input string tag, input int d, input logic b);
    int hi;
    hi = 0;
    check({tag, "_duty"}, 32'(duty_o), 32'(d));
    check({tag, "_busy"}, 32'(busy_o), 32'(b));
    repeat (Period) begin
      tick();
      if (fan_pwm_o === 1'b1) hi++;
    end
    check({tag, "_high"}, 32'(hi), 32'(d * 2));
  endtask

  initial begin
    rst_ni        = 1'b0;
    pwm_setting_i = 4'd0;
    #1;
    check("rst_duty", 32'(duty_o), 32'd0);
    check("rst_pwm", 32'(fan_pwm_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;

    // Short pulse on the setting well inside the first period must be ignored.
    repeat (5) tick();
    pwm_setting_i = 4'd9;
    repeat (5) tick();
    pwm_setting_i = 4'd0;
    repeat (20) tick();
    run_period("glitch", 0, 1'b0);

    pwm_setting_i = 4'd8;
    run_period("pre_kick8", 0, 1'b0);
    repeat (3) run_period("kick8", 15, 1'b1);
    for (int d = 14; d >= 9; d--) repeat (2) run_period("ramp_down", d, 1'b1);
    repeat (2) run_period("hold8", 8, 1'b0);

    pwm_setting_i = 4'd12;
    run_period("hold8_pre", 8, 1'b0);
    for (int d = 9; d <= 11; d++) repeat (2) run_period("ramp_up", d, 1'b1);
    run_period("hold12", 12, 1'b0);

    // Ramp toward 5, redirect to 14 keeping the ramp count, then stop immediately.
    pwm_setting_i = 4'd5;
    run_period("hold12_pre", 12, 1'b0);
    run_period("ramp_to5", 11, 1'b1);
    pwm_setting_i = 4'd14;
    run_period("redirect", 11, 1'b1);
    run_period("redirected", 12, 1'b1);
    pwm_setting_i = 4'd0;
    run_period("pre_stop", 12, 1'b1);
    run_period("stopped", 0, 1'b0);

    pwm_setting_i = 4'd15;
    run_period("pre_kick15", 0, 1'b0);
    repeat (3) run_period("kick15", 15, 1'b1);
    run_period("hold15", 15, 1'b0);
    pwm_setting_i = 4'd0;
    run_period("hold15_pre", 15, 1'b0);
    run_period("stop15", 0, 1'b0);

    // Reset in the middle of a kick must clear outputs without a clock edge.
    pwm_setting_i = 4'd4;
    run_period("pre_kick4", 0, 1'b0);
    repeat (10) tick();
    check("mid_kick_pwm", 32'(fan_pwm_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pwm", 32'(fan_pwm_o), 32'd0);
    check("async_rst_duty", 32'(duty_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (29) tick();
    check("post_rst_duty", 32'(duty_o), 32'd0);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    tick();
    run_period("kick_after_rst", 15, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
